image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per serial bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter BASE_ADDR, default 19'd0, giving the first data-memory address written.
REQ-003 The block SHALL have parameter LENGTH, default 19'd307200, giving the bytes per image (640x480); legal range 1..524287.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port rx, input, 1 bit: the serial line, 8N1, LSB first, idle high, asynchronous to clk.
REQ-007 The block SHALL have port start, input, 1 bit: a level that arms a new image load.
REQ-008 The block SHALL have port m_address, output, 19 bits: the data-memory write address.
REQ-009 The block SHALL have port m_data, output, 8 bits: the data-memory write data.
REQ-010 The block SHALL have port m_wren, output, 1 bit: the data-memory write enable.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: high once LENGTH bytes have been written.
REQ-013 The block SHALL have port frame_err, output, 1 bit: a sticky flag meaning a stop bit was sampled low.
REQ-014 The block SHALL have port byte_count, output, 19 bits: the number of bytes written in the current load.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all line decisions SHALL use the synchronized value rx_s.
REQ-016 The state machine SHALL have states IDLE, WAIT_EDGE, START, DATA, STOP, WRITE, DONE.
REQ-017 IDLE: when start=1, the block SHALL go to WAIT_EDGE, set busy=1, clear byte_count and frame_err, and set done=0.
REQ-018 WAIT_EDGE: a 1->0 transition of rx_s SHALL enter START and clear the bit timer.
REQ-019 A low rx_s held since entering WAIT_EDGE SHALL NOT count as an edge; the block SHALL wait for rx_s=1 first.
REQ-020 START: after CLKS_PER_BIT/2 cycles (integer division), the block SHALL sample rx_s; 0 SHALL enter DATA, and 1 (glitch) SHALL return to WAIT_EDGE without error.
REQ-021 DATA: the block SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, shifting LSB first into the byte register.
REQ-022 STOP: the block SHALL sample CLKS_PER_BIT cycles after the 8th data bit.
REQ-023 If the stop sample is 1, the block SHALL enter WRITE.
REQ-024 If the stop sample is 0, the block SHALL set frame_err=1, discard the byte, leave byte_count unchanged, and return to WAIT_EDGE.
REQ-025 WRITE SHALL last exactly one cycle, with m_wren=1, m_address=BASE_ADDR+byte_count (19-bit, wrap modulo 2^19), and m_data=the received byte.
REQ-026 byte_count SHALL increment on the WRITE cycle.
REQ-027 m_address and m_data SHALL be registered outputs, valid in the same cycle as m_wren, and SHALL hold their last value while m_wren=0.
REQ-028 After WRITE, if the incremented byte_count equals LENGTH, the block SHALL enter DONE; otherwise it SHALL enter WAIT_EDGE.
REQ-029 DONE SHALL hold busy=0, done=1, and m_wren=0, and SHALL ignore rx.
REQ-030 DONE SHALL return to IDLE when start=0; done SHALL remain 1 in IDLE until the next load is armed.
REQ-031 Changes of start while busy=1 SHALL be ignored; a load SHALL NOT be aborted by start.
REQ-032 m_wren SHALL be high for exactly one cycle per accepted byte and SHALL never be high outside WRITE.
REQ-033 Latency: m_wren SHALL rise on the clk edge following the stop-bit sample cycle.
REQ-034 byte_count SHALL never exceed LENGTH, and no write SHALL occur after done=1.

Reset
REQ-035 While rst=1, the block SHALL hold state=IDLE and m_wren=0, m_address=0, m_data=0, busy=0, done=0, frame_err=0, byte_count=0, with the bit timer, bit index and synchronizer set to 1 (idle line).
REQ-036 Assertion of rst mid-frame or mid-WRITE SHALL take effect immediately and asynchronously; the partial byte SHALL be lost and no further write SHALL occur.

Verification (CLKS_PER_BIT=8, BASE_ADDR=19'h10, LENGTH=4)
REQ-037 Bytes 0xA5, 0x3C, 0xFF, 0x00 after start=1 -> four single-cycle m_wren pulses at addresses 0x10..0x13 carrying those bytes; then done=1, busy=0, byte_count=4.
REQ-038 A 3-cycle low glitch on rx in WAIT_EDGE -> no write, frame_err=0, and the next valid byte is written to 0x10.
REQ-039 Byte 0x55 sent with its stop bit low, then 0x66 sent correctly -> frame_err=1, and only 0x66 is written, at 0x10, with byte_count=1.
REQ-040 rst pulsed during the 4th data bit of the 2nd byte -> all outputs return to their reset values; a restarted load writes from 0x10.
REQ-041 start toggled 1->0->1 mid-load -> no effect; DONE is followed by start=0 then start=1 -> a new load begins with byte_count=0 and done=0.
REQ-042 Extra bytes sent after done=1 -> no m_wren pulse, and byte_count stays 4.

Source files
------------

// File: rtl/image_loader_if.sv
// Data-memory write port driven by the image loader: one registered write
// per accepted byte, address/data held between writes.
interface image_loader_if;
    logic [18:0] m_address;
    logic [7:0]  m_data;
    logic        m_wren;

    modport master (output m_address, output m_data, output m_wren);
    modport slave  (input  m_address, input  m_data, input  m_wren);
endinterface

// File: rtl/image_loader.sv
// UART (8N1) image loader: receives LENGTH bytes on rx and writes them to
// consecutive data-memory addresses starting at BASE_ADDR.
module image_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [18:0] BASE_ADDR    = 19'd0,
    parameter logic [18:0] LENGTH       = 19'd307200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  start,
    image_loader_if.master        mem,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err,
    output logic [18:0]           byte_count
);

    localparam int unsigned HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int          TW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_EDGE, START, DATA, STOP, WRITE, DONE
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic          armed_q, armed_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [18:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wren_q, wren_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic [18:0]   cnt_q, cnt_d;
    logic [18:0]   cnt_inc;

    assign cnt_inc = cnt_q + 19'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            armed_q   <= 1'b0;
            timer_q   <= TW'(1);
            bit_idx_q <= 3'd1;
            shift_q   <= 8'd0;
            addr_q    <= 19'd0;
            data_q    <= 8'd0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            cnt_q     <= 19'd0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            armed_q   <= armed_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            cnt_q     <= cnt_d;
        end
    end

    // armed_q records that the line has been seen high since entering
    // WAIT_EDGE, so a line already low on entry is not taken as a start edge.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        ferr_d    = ferr_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_EDGE;
                    armed_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ferr_d  = 1'b0;
                    cnt_d   = 19'd0;
                end
            end
            WAIT_EDGE: begin
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = WAIT_EDGE;
                        armed_d = 1'b0;
                    end
                end
            end
            DATA: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == BIT_M1) begin
                    timer_d   = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == BIT_M1) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        state_d = WRITE;
                        wren_d  = 1'b1;
                        addr_d  = BASE_ADDR + cnt_q;
                        data_d  = shift_q;
                    end else begin
                        state_d = WAIT_EDGE;
                        armed_d = 1'b0;
                        ferr_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == LENGTH) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT_EDGE;
                    armed_d = 1'b0;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.m_address = addr_q;
    assign mem.m_data    = data_q;
    assign mem.m_wren    = wren_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_err     = ferr_q;
    assign byte_count    = cnt_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with CLKS_PER_BIT=8, BASE_ADDR=0x10, LENGTH=4.
module tb_image_loader;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        start;
    logic        busy, done, frame_err;
    logic [18:0] byte_count;

    image_loader_if mem_if ();

    image_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (19'h10),
        .LENGTH      (19'd4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .start     (start),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [18:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    logic        prev_wren = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture every write cycle; a write lasting two cycles is an error.
    always @(negedge clk) begin
        if (mem_if.m_wren === 1'b1) begin
            wq_addr.push_back(mem_if.m_address);
            wq_data.push_back(mem_if.m_data);
            if (prev_wren) chk("wren_single_cycle", 32'd2, 32'd1);
        end
        prev_wren <= (mem_if.m_wren === 1'b1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_write(input string name, input logic [18:0] a, input logic [7:0] d);
        chk({name, "_count"}, wq_addr.size(), 1);
        if (wq_addr.size() > 0) begin
            chk({name, "_addr"}, wq_addr.pop_front(), a);
            chk({name, "_data"}, wq_data.pop_front(), d);
        end
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic        wr;
        logic [18:0] addr;
        logic [18:0] cnt;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        rst = 1'b1; start = 1'b0; rx = 1'b1;
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 19'h10, 19'd1, 1'b1, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 19'h11, 19'd2, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 19'h12, 19'd3, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 19'h13, 19'd4, 1'b0, 1'b1};
        tbl[4] = '{8'h77, 1'b1, 1'b0, 19'h13, 19'd4, 1'b0, 1'b1};

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        chk("rst_wren", mem_if.m_wren, 0);
        chk("rst_addr", mem_if.m_address, 0);
        chk("rst_data", mem_if.m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_cnt", byte_count, 0);

        // Full 4-byte load followed by an extra byte after done
        do_reset();
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("arm_busy", busy, 1);
        chk("arm_cnt", byte_count, 0);
        for (int i = 0; i < 5; i++) begin
            send_byte(tbl[i].b, tbl[i].stop);
            chk($sformatf("v%0d_nwr", i), wq_addr.size(), {31'd0, tbl[i].wr});
            if (tbl[i].wr && wq_addr.size() > 0) begin
                chk($sformatf("v%0d_addr", i), wq_addr.pop_front(), tbl[i].addr);
                chk($sformatf("v%0d_data", i), wq_data.pop_front(), tbl[i].b);
            end
            chk($sformatf("v%0d_cnt", i), byte_count, tbl[i].cnt);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_done", i), done, tbl[i].done);
            chk($sformatf("v%0d_ferr", i), frame_err, 0);
        end

        // Short low glitch while waiting for a start edge
        do_reset();
        start = 1'b1;
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_nwr", wq_addr.size(), 0);
        chk("glitch_ferr", frame_err, 0);
        send_byte(8'h81, 1'b1);
        chk_write("glitch_next", 19'h10, 8'h81);

        // Framing error then a good byte
        do_reset();
        start = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h55, 1'b0);
        chk("ferr_set", frame_err, 1);
        chk("ferr_nwr", wq_addr.size(), 0);
        chk("ferr_cnt", byte_count, 0);
        send_byte(8'h66, 1'b1);
        chk_write("ferr_next", 19'h10, 8'h66);
        chk("ferr_next_cnt", byte_count, 1);
        chk("ferr_sticky", frame_err, 1);

        // Reset during the 4th data bit of the 2nd byte
        do_reset();
        start = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h11, 1'b1);
        chk_write("rstmid_first", 19'h10, 8'h11);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_wren", mem_if.m_wren, 0);
        chk("rstmid_addr", mem_if.m_address, 0);
        chk("rstmid_data", mem_if.m_data, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_cnt", byte_count, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (CPB * 8) @(negedge clk);
        chk("rstmid_nwr", wq_addr.size(), 0);
        start = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h33, 1'b1);
        chk_write("rstmid_restart", 19'h10, 8'h33);

        // start toggled mid-load, then re-arm after DONE
        do_reset();
        start = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("tog_busy", busy, 1);
        chk("tog_cnt", byte_count, 2);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        chk("tog_nwr", wq_addr.size(), 4);
        chk("tog_done", done, 1);
        wq_addr.delete();
        wq_data.delete();
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done_held", done, 1);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rearm_busy", busy, 1);
        chk("rearm_done", done, 0);
        chk("rearm_cnt", byte_count, 0);
        send_byte(8'h42, 1'b1);
        chk_write("rearm_first", 19'h10, 8'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
